// File: rtl/monitor_bus_master.sv
// monitor_bus_master: initiator side of the monitor <-> option-slot byte bus.
// Runs one cmd/reg/data register transaction per request. POLL repeats reads until the
// sampled byte matches req_wdata or POLL_MAX reads have been made.
// Ports:
//   clk_20mhz, reset_x             clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_op/req_cmd/req_reg/req_wdata  request payload (op 0=WRITE 1=READ 2=POLL 3=READ)
//   rsp_valid/rsp_rdata/rsp_count/rsp_timeout  one-cycle response pulse, fields held until the next
//   clk_rw/ax_d/r_wx/slot_x_int_x  bus strobes
//   data_out/data_oe_x/data_in     shared data bus (master drive, active-low enable, card data)
//   int_x/irq_pending              card interrupt (active low) and its synchronised pending flag
module monitor_bus_master #(
    parameter int unsigned PHASE_CYC = 10,
    parameter int unsigned GAP_CYC   = 20,
    parameter int unsigned POLL_MAX  = 64
) (
    input  logic       clk_20mhz,
    input  logic       reset_x,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_cmd,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [7:0] rsp_count,
    output logic       rsp_timeout,
    output logic       clk_rw,
    output logic       ax_d,
    output logic       r_wx,
    output logic       slot_x_int_x,
    output logic [7:0] data_out,
    output logic       data_oe_x,
    input  logic [7:0] data_in,
    input  logic       int_x,
    output logic       irq_pending
);

    localparam int unsigned BW = 8;
    localparam logic [1:0]    OP_WRITE = 2'd0;
    localparam logic [1:0]    OP_POLL  = 2'd2;
    localparam logic [BW-1:0] CMD_INIT = 8'h10;
    localparam logic [BW-1:0] BUS_IDLE = 8'hFF;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD_LO, S_CMD_HI, S_REG_LO, S_REG_HI,
        S_DAT_LO, S_DAT_HI, S_GAP, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] phase_q;
    logic [1:0]    op_q;
    logic [BW-1:0] cmd_q, reg_q, wdata_q, samp_q, cnt_q;
    logic [1:0]    sync_q;

    logic          accept_c, phase_last_c, sample_c, finish_c, is_write_c, slot_sel_c;
    logic [1:0]    op_n;
    logic [BW-1:0] cmd_n, reg_n, wdata_n, samp_c, cnt_c;
    logic          clk_rw_c, ax_d_c, r_wx_c, slot_c, oe_c;
    logic [BW-1:0] dout_c;

    // Request fields as seen by the cycle after this edge (fresh on the accepting edge)
    always_comb begin
        accept_c     = (state == S_IDLE) && req_valid;
        op_n         = accept_c ? req_op    : op_q;
        cmd_n        = accept_c ? req_cmd   : cmd_q;
        reg_n        = accept_c ? req_reg   : reg_q;
        wdata_n      = accept_c ? req_wdata : wdata_q;
        is_write_c   = (op_n == OP_WRITE);
        slot_sel_c   = (cmd_n == CMD_INIT);
        phase_last_c = (phase_q == '0);
    end

    // Data sample on the last DAT_HI cycle; the poll decision uses the freshest sample/count
    always_comb begin
        sample_c = (state == S_DAT_HI) && phase_last_c;
        samp_c   = samp_q;
        cnt_c    = cnt_q;
        if (sample_c) begin
            samp_c = (op_q == OP_WRITE) ? BUS_IDLE : data_in;
            cnt_c  = cnt_q + BW'(1);
        end
        finish_c = (op_q != OP_POLL) || (samp_c == wdata_q) || (cnt_c == BW'(POLL_MAX));
    end

    // Next-state sequencing
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (req_valid)    state_nxt = S_CMD_LO;
            S_CMD_LO: if (phase_last_c) state_nxt = S_CMD_HI;
            S_CMD_HI: if (phase_last_c) state_nxt = S_REG_LO;
            S_REG_LO: if (phase_last_c) state_nxt = S_REG_HI;
            S_REG_HI: if (phase_last_c) state_nxt = S_DAT_LO;
            S_DAT_LO: if (phase_last_c) state_nxt = S_DAT_HI;
            S_DAT_HI: if (phase_last_c) begin
                if (GAP_CYC == 0) state_nxt = finish_c ? S_DONE : S_CMD_LO;
                else              state_nxt = S_GAP;
            end
            S_GAP:    if (phase_last_c) state_nxt = finish_c ? S_DONE : S_CMD_LO;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Bus levels for the state being entered; registered below so they move only at phase boundaries
    always_comb begin
        clk_rw_c = 1'b1;
        ax_d_c   = 1'b1;
        r_wx_c   = 1'b1;
        slot_c   = 1'b1;
        oe_c     = 1'b1;
        dout_c   = BUS_IDLE;
        case (state_nxt)
            S_CMD_LO, S_CMD_HI: begin
                clk_rw_c = (state_nxt == S_CMD_HI);
                ax_d_c   = 1'b0;
                r_wx_c   = 1'b0;
                oe_c     = 1'b0;
                dout_c   = cmd_n;
                slot_c   = !slot_sel_c;
            end
            S_REG_LO, S_REG_HI: begin
                clk_rw_c = (state_nxt == S_REG_HI);
                ax_d_c   = 1'b0;
                r_wx_c   = 1'b0;
                oe_c     = 1'b0;
                dout_c   = reg_n;
                slot_c   = !slot_sel_c;
            end
            S_DAT_LO, S_DAT_HI: begin
                clk_rw_c = (state_nxt == S_DAT_HI);
                slot_c   = !slot_sel_c;
                if (is_write_c) begin
                    r_wx_c = 1'b0;
                    oe_c   = 1'b0;
                    dout_c = wdata_n;
                end
            end
            default: ;
        endcase
    end

    // State, phase timer, request capture, poll bookkeeping and registered outputs
    always_ff @(posedge clk_20mhz or negedge reset_x) begin
        if (!reset_x) begin
            state        <= S_IDLE;
            phase_q      <= '0;
            op_q         <= OP_WRITE;
            cmd_q        <= '0;
            reg_q        <= '0;
            wdata_q      <= '0;
            samp_q       <= BUS_IDLE;
            cnt_q        <= '0;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= BUS_IDLE;
            rsp_count    <= '0;
            rsp_timeout  <= 1'b0;
            clk_rw       <= 1'b1;
            ax_d         <= 1'b1;
            r_wx         <= 1'b1;
            slot_x_int_x <= 1'b1;
            data_out     <= BUS_IDLE;
            data_oe_x    <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                phase_q <= (state_nxt == S_GAP) ? BW'(GAP_CYC - 1) : BW'(PHASE_CYC - 1);
            else if (!phase_last_c)
                phase_q <= phase_q - BW'(1);

            if (accept_c) begin
                op_q    <= req_op;
                cmd_q   <= req_cmd;
                reg_q   <= req_reg;
                wdata_q <= req_wdata;
                samp_q  <= BUS_IDLE;
                cnt_q   <= '0;
            end else if (sample_c) begin
                samp_q <= samp_c;
                cnt_q  <= cnt_c;
            end

            req_ready <= (state_nxt == S_IDLE);
            rsp_valid <= (state_nxt == S_DONE);
            if (state_nxt == S_DONE) begin
                rsp_rdata   <= samp_c;
                rsp_count   <= (op_q == OP_POLL) ? cnt_c : BW'(1);
                rsp_timeout <= (op_q == OP_POLL) && (cnt_c == BW'(POLL_MAX)) && (samp_c != wdata_q);
            end

            clk_rw       <= clk_rw_c;
            ax_d         <= ax_d_c;
            r_wx         <= r_wx_c;
            slot_x_int_x <= slot_c;
            data_out     <= dout_c;
            data_oe_x    <= oe_c;
        end
    end

    // Interrupt synchroniser; pending is high while the card holds int_x low
    always_ff @(posedge clk_20mhz or negedge reset_x) begin
        if (!reset_x) sync_q <= 2'b00;
        else          sync_q <= {sync_q[0], !int_x};
    end

    assign irq_pending = sync_q[1];

endmodule

// File: tb/tb_monitor_bus_master.sv
// tb_monitor_bus_master: directed bench for monitor_bus_master.
// dut uses default timing; dut4 uses PHASE_CYC=2, GAP_CYC=0, POLL_MAX=4.
// Latency is the inclusive cycle count from the handshake cycle to the rsp_valid cycle.
module tb_monitor_bus_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_x, req_valid, req_valid4, int_x;
    logic [1:0] req_op;
    logic [7:0] req_cmd, req_reg, req_wdata;

    logic       req_ready, rsp_valid, rsp_timeout, clk_rw, ax_d, r_wx, slot_x_int_x, data_oe_x, irq_pending;
    logic [7:0] rsp_rdata, rsp_count, data_out, data_in;
    logic       req_ready4, rsp_valid4, rsp_timeout4, clk_rw4, ax_d4, r_wx4, slot4, data_oe_x4, irq_pending4;
    logic [7:0] rsp_rdata4, rsp_count4, data_out4, data_in4;

    monitor_bus_master dut (
        .clk_20mhz(clk), .reset_x(reset_x), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_cmd(req_cmd), .req_reg(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_count(rsp_count), .rsp_timeout(rsp_timeout),
        .clk_rw(clk_rw), .ax_d(ax_d), .r_wx(r_wx), .slot_x_int_x(slot_x_int_x),
        .data_out(data_out), .data_oe_x(data_oe_x), .data_in(data_in),
        .int_x(int_x), .irq_pending(irq_pending)
    );

    monitor_bus_master #(.PHASE_CYC(2), .GAP_CYC(0), .POLL_MAX(4)) dut4 (
        .clk_20mhz(clk), .reset_x(reset_x), .req_valid(req_valid4), .req_ready(req_ready4),
        .req_op(req_op), .req_cmd(req_cmd), .req_reg(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid4), .rsp_rdata(rsp_rdata4), .rsp_count(rsp_count4), .rsp_timeout(rsp_timeout4),
        .clk_rw(clk_rw4), .ax_d(ax_d4), .r_wx(r_wx4), .slot_x_int_x(slot4),
        .data_out(data_out4), .data_oe_x(data_oe_x4), .data_in(data_in4),
        .int_x(1'b1), .irq_pending(irq_pending4)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: records {slot, oe, ax_d, r_wx, data} on each clk_rw rise and counts card reads
    logic [11:0] trace [64];
    logic prev_rw = 1'b1, prev_rw4 = 1'b1;
    int tr_n = 0, rd_cnt = 0, rd_cnt4 = 0, slot_low = 0;
    always @(negedge clk) begin
        if (clk_rw && !prev_rw) begin
            trace[tr_n % 64] = {slot_x_int_x, data_oe_x, ax_d, r_wx, data_out};
            tr_n++;
            if (ax_d && r_wx) rd_cnt++;
        end
        if (clk_rw4 && !prev_rw4 && ax_d4 && r_wx4) rd_cnt4++;
        prev_rw  = clk_rw;
        prev_rw4 = clk_rw4;
        if (!slot_x_int_x) slot_low++;
    end

    // Card models: reads 1..nbusy return busy, later reads return final
    int rd_mark = 0, rd_mark4 = 0, nbusy = 0, nbusy4 = 0;
    logic [7:0] busy_v = 8'h00, final_v = 8'h00, busy_v4 = 8'h00, final_v4 = 8'h00;
    assign data_in  = ((rd_cnt - rd_mark) <= nbusy) ? busy_v : final_v;
    assign data_in4 = ((rd_cnt4 - rd_mark4) <= nbusy4) ? busy_v4 : final_v4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ctl"}, 32'({req_ready, rsp_valid, rsp_timeout, clk_rw, ax_d, r_wx,
                                slot_x_int_x, data_oe_x, irq_pending}), 32'(9'b100111110));
        chk({tag, "_data"}, 32'({data_out, rsp_rdata, rsp_count}), 32'h00FFFF00);
    endtask

    task automatic send(input bit to4, input logic [1:0] op, input logic [7:0] cmd, input logic [7:0] rg,
                        input logic [7:0] wd, output int hs);
        chk("req_ready", 32'(to4 ? req_ready4 : req_ready), 32'd1);
        req_op = op; req_cmd = cmd; req_reg = rg; req_wdata = wd;
        if (to4) req_valid4 = 1'b1; else req_valid = 1'b1;
        hs = cyc;
        @(negedge clk);
        req_valid = 1'b0; req_valid4 = 1'b0;
        req_op = 2'd0; req_cmd = 8'h00; req_reg = 8'h00; req_wdata = 8'h00;
    endtask

    task automatic wait_rsp(input bit to4, output int rc);
        bit got = 1'b0;
        int n = 0;
        rc = -1;
        while (!got && n < 3000) begin
            if ((to4 ? rsp_valid4 : rsp_valid) === 1'b1) begin
                got = 1'b1;
                rc = cyc;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        chk("rsp_seen", 32'(got), 32'd1);
    endtask

    task automatic chk_after(input bit to4);
        @(negedge clk);
        chk("pulse_len", 32'(to4 ? rsp_valid4 : rsp_valid), 32'd0);
        chk("ready_back", 32'(to4 ? req_ready4 : req_ready), 32'd1);
    endtask

    initial begin
        int hs, rc, tm, sm, quiet;
        reset_x = 1'b0; req_valid = 1'b0; req_valid4 = 1'b0; int_x = 1'b1;
        req_op = 2'd0; req_cmd = 8'h00; req_reg = 8'h00; req_wdata = 8'h00;
        repeat (3) @(negedge clk);
        reset_x = 1'b1;
        @(negedge clk);
        chk_reset_vals("reset");

        // WRITE 21/10/09
        tm = tr_n; sm = slot_low;
        send(1'b0, 2'd0, 8'h21, 8'h10, 8'h09, hs);
        wait_rsp(1'b0, rc);
        chk("wr_latency", 32'(rc - hs + 1), 32'd82);
        chk("wr_rsp", 32'({rsp_rdata, rsp_count, 7'd0, rsp_timeout}), 32'hFF0100);
        chk("wr_phases", 32'(tr_n - tm), 32'd3);
        chk("wr_cmd", 32'(trace[tm % 64]), 32'h821);
        chk("wr_reg", 32'(trace[(tm + 1) % 64]), 32'h810);
        chk("wr_dat", 32'(trace[(tm + 2) % 64]), 32'hA09);
        chk("wr_slot_high", 32'(slot_low - sm), 32'd0);
        chk_after(1'b0);

        // READ 23/00, card returns 88
        rd_mark = rd_cnt; nbusy = 0; final_v = 8'h88;
        tm = tr_n;
        send(1'b0, 2'd1, 8'h23, 8'h00, 8'h00, hs);
        wait_rsp(1'b0, rc);
        chk("rd_latency", 32'(rc - hs + 1), 32'd82);
        chk("rd_rsp", 32'({rsp_rdata, rsp_count, 7'd0, rsp_timeout}), 32'h880100);
        chk("rd_cmd", 32'(trace[tm % 64]), 32'h823);
        chk("rd_reg", 32'(trace[(tm + 1) % 64]), 32'h800);
        chk("rd_dat", 32'(trace[(tm + 2) % 64]), 32'hFFF);
        chk_after(1'b0);

        // POLL 22/27 expect 00: 13 busy reads then 00
        rd_mark = rd_cnt; nbusy = 13; busy_v = 8'h09; final_v = 8'h00;
        tm = tr_n;
        send(1'b0, 2'd2, 8'h22, 8'h27, 8'h00, hs);
        wait_rsp(1'b0, rc);
        chk("poll_latency", 32'(rc - hs + 1), 32'd1122);
        chk("poll_rsp", 32'({rsp_rdata, rsp_count, 7'd0, rsp_timeout}), 32'h000E00);
        chk("poll_phases", 32'(tr_n - tm), 32'd42);
        chk("poll_reads", 32'(rd_cnt - rd_mark), 32'd14);
        chk_after(1'b0);

        // POLL on dut4 never matches: timeout after 4 reads
        rd_mark4 = rd_cnt4; nbusy4 = 100; busy_v4 = 8'h09;
        send(1'b1, 2'd2, 8'h22, 8'h27, 8'h00, hs);
        wait_rsp(1'b1, rc);
        chk("to_latency", 32'(rc - hs + 1), 32'd50);
        chk("to_rsp", 32'({rsp_rdata4, rsp_count4, 7'd0, rsp_timeout4}), 32'h090401);
        chk("to_reads", 32'(rd_cnt4 - rd_mark4), 32'd4);
        chk_after(1'b1);

        // POLL on dut4 matching on the final allowed read: no timeout
        rd_mark4 = rd_cnt4; nbusy4 = 3; busy_v4 = 8'h09; final_v4 = 8'h00;
        send(1'b1, 2'd2, 8'h22, 8'h27, 8'h00, hs);
        wait_rsp(1'b1, rc);
        chk("lastmatch_rsp", 32'({rsp_rdata4, rsp_count4, 7'd0, rsp_timeout4}), 32'h000400);

        // Reserved op 3 behaves as READ, and rsp_timeout clears
        @(negedge clk);
        rd_mark4 = rd_cnt4; nbusy4 = 0; final_v4 = 8'h5A;
        send(1'b1, 2'd3, 8'h23, 8'h01, 8'h00, hs);
        wait_rsp(1'b1, rc);
        chk("op3_rsp", 32'({rsp_rdata4, rsp_count4, 7'd0, rsp_timeout4}), 32'h5A0100);
        chk_after(1'b1);

        // WRITE 10/03/05 pulls slot select low for exactly six phases
        tm = tr_n; sm = slot_low;
        send(1'b0, 2'd0, 8'h10, 8'h03, 8'h05, hs);
        wait_rsp(1'b0, rc);
        chk("slot_low_cyc", 32'(slot_low - sm), 32'd60);
        chk("slot_cmd", 32'(trace[tm % 64]), 32'h010);
        chk("slot_reg", 32'(trace[(tm + 1) % 64]), 32'h003);
        chk("slot_dat", 32'(trace[(tm + 2) % 64]), 32'h205);
        chk("slot_idle", 32'(slot_x_int_x), 32'd1);
        chk_after(1'b0);

        // Interrupt synchroniser: two-edge latency both ways
        int_x = 1'b0;
        @(negedge clk);
        chk("irq_1edge", 32'(irq_pending), 32'd0);
        @(negedge clk);
        chk("irq_set", 32'(irq_pending), 32'd1);
        int_x = 1'b1;
        repeat (2) @(negedge clk);
        chk("irq_clr", 32'(irq_pending), 32'd0);

        // Reset during REG_HI of a READ aborts without a response
        rd_mark = rd_cnt; nbusy = 0; final_v = 8'h77;
        send(1'b0, 2'd1, 8'h23, 8'h00, 8'h00, hs);
        repeat (34) @(negedge clk);
        chk("in_reg_hi", 32'({clk_rw, ax_d, r_wx, data_oe_x, data_out}), 32'h800);
        reset_x = 1'b0;
        #1;
        chk_reset_vals("midreset");
        @(negedge clk);
        reset_x = 1'b1;
        quiet = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid) quiet++;
        end
        chk("no_rsp_after_abort", 32'(quiet), 32'd0);

        // Next request completes normally
        send(1'b0, 2'd0, 8'h21, 8'h10, 8'h09, hs);
        wait_rsp(1'b0, rc);
        chk("post_latency", 32'(rc - hs + 1), 32'd82);
        chk("post_rsp", 32'({rsp_rdata, rsp_count, 7'd0, rsp_timeout}), 32'hFF0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
